logic_operand_sequencer: RTL and testbench
==========================================

// Module: logic_operand_sequencer
// PURPOSE
//  Upstream/downstream wrapper for the 8-bit bitwise logic unit (NAND stage) of the DSP datapath.
//  Collects two operands serially from the shared data bus and holds them steady on OpA/OpB.
//  Waits EXEC_LAT cycles for the logic unit, captures its output, then presents the result
//  on a valid/ready interface to the writeback stage.
// PARAMETERS
//  WIDTH     8  operand/result width; matches logic-unit In1/In2/Out
//  EXEC_LAT  1  cycles from operand B accept to result capture; legal range 1..15
// PORTS
//  Clk        in   1      system clock, rising edge
//  Rst_n      in   1      asynchronous active-low reset
//  In_data    in   WIDTH  operand byte from data bus
//  In_valid   in   1      In_data is valid
//  In_ready   out  1      block accepts an operand this cycle
//  Clear      in   1      synchronous abort of the current operation
//  OpA        out  WIDTH  registered operand A -> logic unit In1
//  OpB        out  WIDTH  registered operand B -> logic unit In2
//  GateOut    in   WIDTH  logic unit Out (combinational from OpA/OpB)
//  Res_data   out  WIDTH  captured result
//  Res_valid  out  1      Res_data is valid
//  Res_ready  in   1      downstream accepts the result
//  Busy       out  1      high in any state other than S_A
//  ResCount   out  8      number of completed result handshakes, wraps at 255->0
// BEHAVIOUR
//  Clock and reset: one clock, Clk. Rst_n is asynchronous and active-low.
//  Reset (Rst_n=0, asynchronous): state=S_A; OpA, OpB, Res_data, ResCount and the latency counter
//   all clear to 0. Res_valid=0, In_ready=1, Busy=0. Reset asserted mid-operation discards
//   everything.
//  FSM states: S_A -> S_B -> S_EXEC -> S_OUT -> S_A.
//  S_A:
//   - In_ready=1.
//   - On an edge with In_valid=1: OpA<=In_data, go to S_B.
//  S_B:
//   - In_ready=1.
//   - On an edge with In_valid=1: OpB<=In_data, cnt<=EXEC_LAT-1, go to S_EXEC.
//  S_EXEC:
//   - In_ready=0.
//   - On each edge: if cnt==0 then Res_data<=GateOut and go to S_OUT; otherwise cnt<=cnt-1.
//  S_OUT:
//   - Res_valid=1, In_ready=0.
//   - Res_data is held stable until the handshake.
//   - On an edge with Res_ready=1: ResCount<=ResCount+1 (mod 256), go to S_A.
//  Latency:
//   - Operand B accepted at edge k -> Res_valid high after edge k+EXEC_LAT.
//   - Minimum period from A accept to A accept is EXEC_LAT+3 cycles with Res_ready held 1.
//  OpA/OpB change only when their operand is accepted; they are held through S_EXEC and S_OUT.
//  Clear (synchronous, highest priority after reset):
//   - Next state is S_A, and Res_valid drops the next cycle.
//   - OpA, OpB, Res_data and ResCount keep their values.
//   - No operand is accepted and no handshake is counted on a Clear cycle,
//     even if In_valid or Res_ready is also high.
//  In_valid while In_ready=0 is ignored; the data is not buffered.
//  Res_ready while Res_valid=0 is ignored.
//  In_ready, Res_valid and Busy are decoded from the state register only (no combinational
//   path from inputs).
// TESTING
//  1. Reset values: drive Rst_n=0 mid-S_EXEC -> immediately OpA=OpB=Res_data=0, Res_valid=0,
//     In_ready=1, ResCount=0.
//  2. Basic op, EXEC_LAT=1: A=0xF0, B=0x3C, Res_ready=1 -> Res_data=0xCF one cycle after B
//     accepted; ResCount=1.
//  3. Backpressure: A=0xFF, B=0xFF, Res_ready=0 for 5 cycles -> Res_valid stays 1 and
//     Res_data=0x00 stays stable; In_ready=0 and extra In_valid pulses are ignored.
//  4. Clear: assert in S_B after A=0xAA -> S_A, OpA stays 0xAA; next A=0x0F, B=0xF0 ->
//     Res_data=0xFF.
//  5. EXEC_LAT=4: B accepted at edge k -> Res_valid rises after edge k+4; Clear together with
//     Res_ready in S_OUT -> ResCount unchanged.
//  6. Wrap: 256 back-to-back operations -> ResCount returns to 0x00; the throughput check
//     confirms EXEC_LAT+3 cycles per operation.

Source files
------------

// File: rtl/logic_operand_sequencer_if.sv
// Operand-in and result-out handshake bundle between the data bus, the
// operand sequencer and the writeback stage.
interface logic_operand_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_valid;
    logic             res_ready;

    // Environment side: supplies operands, consumes results.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  res_data,
        input  res_valid,
        output res_ready
    );

    // Sequencer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output res_data,
        output res_valid,
        input  res_ready
    );
endinterface

// File: rtl/logic_operand_sequencer.sv
// Collects two operands serially for the NAND logic unit, waits EXEC_LAT cycles,
// captures its output and offers it on a valid/ready result port.
module logic_operand_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned EXEC_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    logic_operand_sequencer_if.slave  bus,
    input  logic                      clear,
    output logic [WIDTH-1:0]          op_a,
    output logic [WIDTH-1:0]          op_b,
    input  logic [WIDTH-1:0]          gate_out,
    output logic                      busy,
    output logic [7:0]                res_count
);

    if (EXEC_LAT < 1 || EXEC_LAT > 15) begin : g_bad_lat
        $error("EXEC_LAT must be in 1..15");
    end

    localparam logic [3:0] CntInit = 4'(EXEC_LAT - 1);

    typedef enum logic [1:0] {
        StA    = 2'd0,
        StB    = 2'd1,
        StExec = 2'd2,
        StOut  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [7:0]       res_count_q, res_count_d;
    logic [3:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StA;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_count_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        cnt_d       = cnt_q;
        // Clear aborts without touching any datapath register.
        if (clear) begin
            state_d = StA;
        end else begin
            case (state_q)
                StA: begin
                    if (bus.in_valid) begin
                        op_a_d  = bus.in_data;
                        state_d = StB;
                    end
                end
                StB: begin
                    if (bus.in_valid) begin
                        op_b_d  = bus.in_data;
                        cnt_d   = CntInit;
                        state_d = StExec;
                    end
                end
                StExec: begin
                    if (cnt_q == 4'd0) begin
                        res_data_d = gate_out;
                        state_d    = StOut;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StOut: begin
                    if (bus.res_ready) begin
                        res_count_d = res_count_q + 8'd1;
                        state_d     = StA;
                    end
                end
                default: state_d = StA;
            endcase
        end
    end

    // Handshake flags come from the state register alone.
    assign bus.in_ready  = (state_q == StA) || (state_q == StB);
    assign bus.res_valid = (state_q == StOut);
    assign bus.res_data  = res_data_q;
    assign busy          = (state_q != StA);
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign res_count     = res_count_q;

endmodule

// File: tb/tb_logic_operand_sequencer.sv
// Directed bench: EXEC_LAT=1 and EXEC_LAT=4 sequencers, each driving a NAND model
// as the logic unit.
module tb_logic_operand_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic_operand_sequencer_if #(.WIDTH(8)) if1 ();
    logic_operand_sequencer_if #(.WIDTH(8)) if4 ();

    logic       clear1 = 1'b0, clear4 = 1'b0;
    logic [7:0] op_a1, op_b1, op_a4, op_b4, gate1, gate4, cnt1, cnt4;
    logic       busy1, busy4;

    assign gate1 = ~(op_a1 & op_b1);
    assign gate4 = ~(op_a4 & op_b4);

    logic_operand_sequencer #(.WIDTH(8), .EXEC_LAT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if1),
        .clear     (clear1),
        .op_a      (op_a1),
        .op_b      (op_b1),
        .gate_out  (gate1),
        .busy      (busy1),
        .res_count (cnt1)
    );

    logic_operand_sequencer #(.WIDTH(8), .EXEC_LAT(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if4),
        .clear     (clear4),
        .op_a      (op_a4),
        .op_b      (op_b4),
        .gate_out  (gate4),
        .busy      (busy4),
        .res_count (cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents A then B on consecutive edges; returns just after the B-accept edge.
    task automatic send_op(input bit sel4, input logic [7:0] a, input logic [7:0] b);
        if (sel4) begin
            if4.in_valid = 1'b1; if4.in_data = a; tick();
            if4.in_data = b; tick();
            if4.in_valid = 1'b0;
        end else begin
            if1.in_valid = 1'b1; if1.in_data = a; tick();
            if1.in_data = b; tick();
            if1.in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (if1.in_ready !== 1'b1 || if1.res_valid !== 1'b0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy=%b vld=%b busy=%b, want 1 0 0",
                     if1.in_ready, if1.res_valid, busy1);
        end
        tick();
        rst_n = 1'b1;
        tick();
        // Reset asserted while dut1 sits in its execute state.
        send_op(1'b0, 8'h12, 8'h34);
        vectors++;
        if (busy1 !== 1'b1 || op_a1 !== 8'h12 || op_b1 !== 8'h34) begin
            miscompares++;
            $display("FAIL pre_reset_exec: got busy=%b a=%h b=%h, want 1 12 34",
                     busy1, op_a1, op_b1);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (op_a1 !== 8'h00 || op_b1 !== 8'h00 || if1.res_data !== 8'h00 ||
            if1.res_valid !== 1'b0 || if1.in_ready !== 1'b1 || cnt1 !== 8'h00 ||
            busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_exec: got a=%h b=%h r=%h vld=%b rdy=%b cnt=%h busy=%b, want 00 00 00 0 1 00 0",
                     op_a1, op_b1, if1.res_data, if1.res_valid, if1.in_ready, cnt1, busy1);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        if1.res_ready = 1'b1;
        send_op(1'b0, 8'hF0, 8'h3C);
        vectors++;
        if (if1.res_valid !== 1'b0 || if1.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_exec: got vld=%b rdy=%b, want 0 0", if1.res_valid, if1.in_ready);
        end
        tick();
        vectors++;
        if (if1.res_valid !== 1'b1 || if1.res_data !== 8'hCF || cnt1 !== 8'd0) begin
            miscompares++;
            $display("FAIL basic_result: got vld=%b r=%h cnt=%0d, want 1 cf 0",
                     if1.res_valid, if1.res_data, cnt1);
        end
        tick();
        vectors++;
        if (cnt1 !== 8'd1 || if1.res_valid !== 1'b0 || if1.in_ready !== 1'b1 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_handshake: got cnt=%0d vld=%b rdy=%b busy=%b, want 1 0 1 0",
                     cnt1, if1.res_valid, if1.in_ready, busy1);
        end
    endtask

    task automatic test_backpressure();
        if1.res_ready = 1'b0;
        send_op(1'b0, 8'hFF, 8'hFF);
        tick();
        for (int i = 0; i < 5; i++) begin
            if1.in_valid = 1'b1;
            if1.in_data  = 8'h55;
            tick();
            vectors++;
            if (if1.res_valid !== 1'b1 || if1.res_data !== 8'h00 || if1.in_ready !== 1'b0 ||
                op_a1 !== 8'hFF || op_b1 !== 8'hFF || cnt1 !== 8'd1) begin
                miscompares++;
                $display("FAIL backpressure_%0d: got vld=%b r=%h rdy=%b a=%h b=%h cnt=%0d, want 1 00 0 ff ff 1",
                         i, if1.res_valid, if1.res_data, if1.in_ready, op_a1, op_b1, cnt1);
            end
        end
        if1.in_valid  = 1'b0;
        if1.res_ready = 1'b1;
        tick();
        vectors++;
        if (cnt1 !== 8'd2 || if1.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release: got cnt=%0d rdy=%b, want 2 1", cnt1, if1.in_ready);
        end
    endtask

    task automatic test_clear();
        if1.in_valid = 1'b1;
        if1.in_data  = 8'hAA;
        tick();
        // Clear with a competing operand offer in the B state.
        clear1       = 1'b1;
        if1.in_data  = 8'h77;
        tick();
        clear1       = 1'b0;
        if1.in_valid = 1'b0;
        vectors++;
        if (busy1 !== 1'b0 || if1.in_ready !== 1'b1 || op_a1 !== 8'hAA || op_b1 !== 8'hFF ||
            if1.res_data !== 8'h00 || cnt1 !== 8'd2) begin
            miscompares++;
            $display("FAIL clear_in_b: got busy=%b rdy=%b a=%h b=%h r=%h cnt=%0d, want 0 1 aa ff 00 2",
                     busy1, if1.in_ready, op_a1, op_b1, if1.res_data, cnt1);
        end
        send_op(1'b0, 8'h0F, 8'hF0);
        tick();
        vectors++;
        if (if1.res_valid !== 1'b1 || if1.res_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL clear_next_op: got vld=%b r=%h, want 1 ff", if1.res_valid, if1.res_data);
        end
        tick();
        vectors++;
        if (cnt1 !== 8'd3) begin
            miscompares++;
            $display("FAIL clear_next_count: got %0d, want 3", cnt1);
        end
    endtask

    task automatic test_exec_lat4();
        if4.res_ready = 1'b0;
        send_op(1'b1, 8'hC3, 8'h81);
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (if4.res_valid !== 1'b0 || busy4 !== 1'b1) begin
                miscompares++;
                $display("FAIL lat4_wait_%0d: got vld=%b busy=%b, want 0 1", i, if4.res_valid, busy4);
            end
        end
        tick();
        vectors++;
        if (if4.res_valid !== 1'b1 || if4.res_data !== 8'h7E) begin
            miscompares++;
            $display("FAIL lat4_result: got vld=%b r=%h, want 1 7e", if4.res_valid, if4.res_data);
        end
        // Clear coinciding with a handshake must not count it.
        clear4        = 1'b1;
        if4.res_ready = 1'b1;
        tick();
        clear4        = 1'b0;
        if4.res_ready = 1'b0;
        vectors++;
        if (if4.res_valid !== 1'b0 || cnt4 !== 8'd0 || if4.in_ready !== 1'b1 ||
            if4.res_data !== 8'h7E || op_a4 !== 8'hC3) begin
            miscompares++;
            $display("FAIL lat4_clear_out: got vld=%b cnt=%0d rdy=%b r=%h a=%h, want 0 0 1 7e c3",
                     if4.res_valid, cnt4, if4.in_ready, if4.res_data, op_a4);
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if1.res_ready = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_data   = 8'h5A;
        tick();
        // Four cycles per operation: 255 done after 1020 edges, 256th result shown at 1023.
        for (int i = 1; i < 1023; i++) tick();
        vectors++;
        if (cnt1 !== 8'd255 || if1.res_valid !== 1'b1 || if1.res_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL wrap_pre: got cnt=%0d vld=%b r=%h, want 255 1 a5",
                     cnt1, if1.res_valid, if1.res_data);
        end
        tick();
        if1.in_valid = 1'b0;
        vectors++;
        if (cnt1 !== 8'd0 || if1.in_ready !== 1'b1 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_done: got cnt=%0d rdy=%b busy=%b, want 0 1 0",
                     cnt1, if1.in_ready, busy1);
        end
    endtask

    initial begin
        if1.in_data = '0; if1.in_valid = 1'b0; if1.res_ready = 1'b0;
        if4.in_data = '0; if4.in_valid = 1'b0; if4.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_exec_lat4();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
